// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory: 32-bit stores on the rising edge,
// 32-bit combinational loads; lanes wrap modulo DEPTH_BYTES so unaligned access works anywhere.
module data_mem #(
   parameter  int DEPTH_BYTES = 1024,
   localparam int ADDR_BITS   = $clog2(DEPTH_BYTES)
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic [31:0] addrIn,
   input  logic [31:0] dataW,
   input  logic        memW,
   input  logic        memR,
   output logic [31:0] dataR
);

   logic [7:0]           mem_q [DEPTH_BYTES];
   logic [ADDR_BITS-1:0] lane0;
   logic [ADDR_BITS-1:0] lane1;
   logic [ADDR_BITS-1:0] lane2;
   logic [ADDR_BITS-1:0] lane3;
   logic                 unused_addr_hi;

   // Lane indices are ADDR_BITS wide, so the +1..+3 carry-out drops and the word wraps to byte 0.
   assign lane0 = addrIn[ADDR_BITS-1:0];
   assign lane1 = lane0 + ADDR_BITS'(1);
   assign lane2 = lane0 + ADDR_BITS'(2);
   assign lane3 = lane0 + ADDR_BITS'(3);

   assign unused_addr_hi = ^addrIn[31:ADDR_BITS];

   always_ff @(posedge clk) begin
      if (!rstN) begin
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (memW) begin
         mem_q[lane0] <= dataW[7:0];
         mem_q[lane1] <= dataW[15:8];
         mem_q[lane2] <= dataW[23:16];
         mem_q[lane3] <= dataW[31:24];
      end
   end

   always_comb begin
      dataR = 32'h0000_0000;
      if (memR) begin
         dataR = {mem_q[lane3], mem_q[lane2], mem_q[lane1], mem_q[lane0]};
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed cases with literal expectations plus randomized traffic
// checked against a plain byte-array model through an expected-value queue.
module tb_data_mem;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rstN = 1'b1;
   logic [31:0] addrIn = '0;
   logic [31:0] dataW = '0;
   logic        memW = 1'b0;
   logic        memR = 1'b0;
   logic [31:0] dataR;

   data_mem #(.DEPTH_BYTES(DEPTH)) dut (
      .clk    (clk),
      .rstN   (rstN),
      .addrIn (addrIn),
      .dataW  (dataW),
      .memW   (memW),
      .memR   (memR),
      .dataR  (dataR)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [DEPTH];

   function automatic logic [31:0] ref_rd(input logic [31:0] addr);
      int unsigned a;
      logic [31:0] w;
      a = addr % DEPTH;
      for (int k = 0; k < 4; k++) begin
         w[8*k +: 8] = ref_mem[(a + k) % DEPTH];
      end
      return w;
   endfunction

   task automatic ref_wr(input logic [31:0] addr, input logic [31:0] data);
      int unsigned a;
      a = addr % DEPTH;
      for (int k = 0; k < 4; k++) begin
         ref_mem[(a + k) % DEPTH] = data[8*k +: 8];
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        chk_en = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got %08h, required a queued expectation", dataR);
         end else begin
            logic [31:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (dataR !== e) begin
               n_fail++;
               $display("FAIL %s: addr=%08h got %08h, required %08h", nm, addrIn, dataR, e);
            end
         end
      end
   end

   // ---------------- driver tasks (entered and left at posedge+1) ----------------
   task automatic expect_now(input logic [31:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      chk_en = 1'b1;
      @(negedge clk);
      #1 chk_en = 1'b0;
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      @(posedge clk);
      ref_clear();
      #1 rstN = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      addrIn = addr;
      dataW  = data;
      memW   = 1'b1;
      memR   = 1'b0;
      @(posedge clk);
      ref_wr(addr, data);
      #1 memW = 1'b0;
   endtask

   // Read with a literal expectation.
   task automatic read_lit(input logic [31:0] addr, input logic rd,
                           input logic [31:0] e, input string nm);
      addrIn = addr;
      memR   = rd;
      memW   = 1'b0;
      expect_now(e, nm);
      @(posedge clk);
      #1;
   endtask

   // Read checked against the model.
   task automatic read_ref(input logic [31:0] addr, input logic rd, input string nm);
      read_lit(addr, rd, rd ? ref_rd(addr) : 32'h0, nm);
   endtask

   // Simultaneous read and write: old data before the edge, new data after it.
   task automatic read_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic use_lit, input logic [31:0] e_old,
                             input logic [31:0] e_new, input string nm);
      addrIn = addr;
      dataW  = data;
      memR   = 1'b1;
      memW   = 1'b1;
      expect_now(use_lit ? e_old : ref_rd(addr), {nm, "_before"});
      @(posedge clk);
      ref_wr(addr, data);
      #1 memW = 1'b0;
      expect_now(use_lit ? e_new : ref_rd(addr), {nm, "_after"});
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      @(posedge clk);
      #1;
      do_reset();
      read_lit(32'd0,   1'b1, 32'h0, "reset_addr0");
      read_lit(32'd511, 1'b1, 32'h0, "reset_addr511");
      read_lit(32'd1022, 1'b1, 32'h0, "reset_top_wrap");

      // aligned write/read, memR gating, unaligned read
      do_write(32'd0, 32'hA28B538C);
      read_lit(32'd0, 1'b1, 32'hA28B538C, "aligned_read");
      read_lit(32'd0, 1'b0, 32'h00000000, "memR_low_zero");
      read_lit(32'd3, 1'b1, 32'h000000A2, "unaligned_read3");
      read_lit(32'd1, 1'b1, 32'h00A28B53, "unaligned_read1");

      // unaligned write and upper-bit aliasing
      do_reset();
      do_write(32'd2, 32'h11223344);
      read_lit(32'd0, 1'b1, 32'h33440000, "unal_wr_read0");
      read_lit(32'd4, 1'b1, 32'h00001122, "unal_wr_read4");
      read_lit(DEPTH + 2, 1'b1, 32'h11223344, "alias_read");
      read_lit(32'hFFFF_0000 + 2, 1'b1, 32'h11223344, "alias_read_hi");

      // wrap at the top of memory
      do_reset();
      do_write(DEPTH - 2, 32'hDEADBEEF);
      read_lit(DEPTH - 2, 1'b1, 32'hDEADBEEF, "wrap_read_top");
      read_lit(32'd0, 1'b1, 32'h0000DEAD, "wrap_read0");

      // simultaneous read/write
      do_reset();
      do_write(32'd0, 32'hA28B538C);
      read_write(32'd0, 32'h0000FFFF, 1'b1, 32'hA28B538C, 32'h0000FFFF, "rw_same_cycle");

      // reset mid-operation with memW high
      do_write(32'd8, 32'hCAFEF00D);
      addrIn = 32'd0;
      dataW  = 32'h12345678;
      memW   = 1'b1;
      rstN   = 1'b0;
      @(posedge clk);
      ref_clear();
      #1 rstN = 1'b1;
      memW = 1'b0;
      read_lit(32'd0, 1'b1, 32'h0, "reset_discards_write");
      read_lit(32'd8, 1'b1, 32'h0, "reset_clears_loaded");

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] addr;
         logic [31:0] data;
         int          op;
         data = $urandom;
         if ($urandom_range(0, 3) == 0)
            addr = ($urandom & 32'hFFFF_FC00) | (DEPTH - 1 - $urandom_range(0, 4));
         else
            addr = $urandom;
         op = $urandom_range(0, 19);
         if (op < 8)        do_write(addr, data);
         else if (op < 16)  read_ref(addr, 1'b1, "rand_read");
         else if (op < 18)  read_ref(addr, 1'b0, "rand_read_off");
         else if (op < 19)  read_write(addr, data, 1'b0, 32'h0, 32'h0, "rand_rw");
         else begin
            do_reset();
            read_ref(addr, 1'b1, "rand_after_reset");
         end
      end

      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
